unidade_controle: RTL

Multi-cycle control unit that fetches 16-bit instructions, decodes them, drives the ALU's `opcode`/`operando1`/`operando2` inputs, and consumes its `resultado`/`data_uc` outputs for register write-back and conditional branching. It owns the program counter and an 8×16 register file. It sits between the instruction memory and the ALU, forming the initiator side of the ALU interface.

---
 rtl/unidade_controle.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetches 16-bit instructions, drives the ALU
// operands, writes results back into an 8x16 register file and resolves
// branches from the ALU condition flag.
module unidade_controle (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic [7:0]  pc,
    output logic        mem_rd,
    input  logic [15:0] instr,
    output logic [4:0]  opcode,
    output logic [15:0] operando1,
    output logic [15:0] operando2,
    input  logic [31:0] resultado,
    input  logic        data_uc,
    output logic        halted,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        HALTED  = 3'd4
    } state_t;

    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_JMP  = 5'b01110;
    localparam logic [4:0] OP_HALT = 5'b11111;

    state_t      state_reg, state_next;
    logic [7:0]  pc_reg, pc_next;
    logic [15:0] ir_reg;
    logic [4:0]  opcode_reg, opcode_next;
    logic [15:0] op1_reg, op1_next;
    logic [15:0] op2_reg, op2_next;
    logic [15:0] regs [8];

    logic        wr_en;
    logic [15:0] wr_data;
    logic [7:0]  wr_sel;

    // ALU opcodes: 00010 and the contiguous range 00100..01101
    function automatic logic is_alu(input logic [4:0] op);
        return (op == 5'b00010) || ((op >= 5'b00100) && (op <= 5'b01101));
    endfunction

    // Conditional branches: 01111..10011, condition supplied by the ALU
    function automatic logic is_branch(input logic [4:0] op);
        return (op >= 5'b01111) && (op <= 5'b10011);
    endfunction

    // Fields of the word arriving from memory (used while in DECODE)
    logic [4:0] in_op;
    logic [2:0] in_rd, in_rs, in_rt;
    assign in_op = instr[15:11];
    assign in_rd = instr[10:8];
    assign in_rs = instr[7:5];
    assign in_rt = instr[4:2];

    // Fields of the latched instruction (used while in EXECUTE)
    logic [4:0] ir_op;
    logic [2:0] ir_rd;
    logic [7:0] ir_imm;
    assign ir_op  = ir_reg[15:11];
    assign ir_rd  = ir_reg[10:8];
    assign ir_imm = ir_reg[7:0];

    // Operand selection straight from the incoming instruction word
    always_comb begin
        opcode_next = 5'd0;
        op1_next    = 16'd0;
        op2_next    = 16'd0;
        if (is_alu(in_op)) begin
            opcode_next = in_op;
            op1_next    = regs[in_rs];
            op2_next    = regs[in_rt];
        end else if (is_branch(in_op)) begin
            opcode_next = in_op;
            op1_next    = regs[in_rd];
        end
    end

    // Next-state, strobes, write-back and pc update
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        mem_rd     = 1'b0;
        halted     = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 16'd0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                mem_rd     = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                state_next = EXECUTE;
            end
            EXECUTE: begin
                state_next = FETCH;
                pc_next    = pc_reg + 8'd1;
                if (is_alu(ir_op)) begin
                    wr_en   = 1'b1;
                    wr_data = resultado[15:0];
                end else if (is_branch(ir_op)) begin
                    if (data_uc) pc_next = ir_imm;
                end else if (ir_op == OP_LDI) begin
                    wr_en   = 1'b1;
                    wr_data = {8'h00, ir_imm};
                end else if (ir_op == OP_JMP) begin
                    pc_next = ir_imm;
                end else if (ir_op == OP_HALT) begin
                    pc_next    = pc_reg;
                    state_next = HALTED;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // One-hot write select per register
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_wsel
            assign wr_sel[gi] = wr_en && (ir_rd == 3'(gi));
        end
    endgenerate

    // State, pc, instruction register and registered ALU inputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            pc_reg     <= 8'd0;
            ir_reg     <= 16'd0;
            opcode_reg <= 5'd0;
            op1_reg    <= 16'd0;
            op2_reg    <= 16'd0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (state_reg == DECODE) begin
                ir_reg     <= instr;
                opcode_reg <= opcode_next;
                op1_reg    <= op1_next;
                op2_reg    <= op2_next;
            end
        end
    end

    // Register file; writes land at the closing edge of EXECUTE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_sel[i]) regs[i] <= wr_data;
            end
        end
    end

    assign pc        = pc_reg;
    assign opcode    = opcode_reg;
    assign operando1 = op1_reg;
    assign operando2 = op2_reg;
    assign dbg_data  = regs[dbg_addr];

endmodule
